// File: rtl/tinyfpga_boot_sequencer_if.sv
// Signal bundle between the boot sequencer and its surroundings: bootloader
// request/busy inputs, flash pin drive, warmboot primitive inputs and debug state.
interface tinyfpga_boot_sequencer_if;
  logic       boot_req;
  logic       spi_busy;
  logic       spi_own;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic [1:0] warmboot_s;
  logic       warmboot_boot;
  logic [2:0] state_dbg;

  modport slave (
    input  boot_req,
    input  spi_busy,
    output spi_own,
    output spi_cs,
    output spi_sck,
    output spi_mosi,
    output warmboot_s,
    output warmboot_boot,
    output state_dbg
  );

  modport master (
    output boot_req,
    output spi_busy,
    input  spi_own,
    input  spi_cs,
    input  spi_sck,
    input  spi_mosi,
    input  warmboot_s,
    input  warmboot_boot,
    input  state_dbg
  );
endinterface

// File: rtl/tinyfpga_boot_sequencer.sv
// Boot hand-off sequencer: waits for the bootloader to release the flash, wakes it
// with one SPI command, waits a guard time, then fires the warmboot primitive.
module tinyfpga_boot_sequencer #(
  parameter logic [7:0]  SPI_CMD         = 8'hAB,
  parameter int unsigned SPI_HALF_PERIOD = 2,
  parameter int unsigned GUARD_CYCLES    = 4800,
  parameter logic [1:0]  IMAGE_SEL       = 2'b01
) (
  input  logic                        clk_48mhz,
  input  logic                        reset,
  tinyfpga_boot_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_CS_SETUP  = 3'd2,
    S_SHIFT     = 3'd3,
    S_CS_HOLD   = 3'd4,
    S_GUARD     = 3'd5,
    S_BOOT      = 3'd6
  } state_e;

  localparam logic [7:0]  PHASE_LAST = 8'(SPI_HALF_PERIOD - 1);
  localparam logic [19:0] GUARD_LAST = 20'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [2:0]  bit_q,   bit_d;
  logic [19:0] guard_q, guard_d;
  logic        own_q,   own_d;
  logic        cs_q,    cs_d;
  logic        sck_q,   sck_d;
  logic        mosi_q,  mosi_d;
  logic        boot_q,  boot_d;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      guard_q <= '0;
      own_q   <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      guard_q <= guard_d;
      own_q   <= own_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      boot_q  <= boot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    guard_d = guard_q;
    own_d   = own_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    boot_d  = boot_q;

    unique case (state_q)
      // Leaving IDLE is the sticky record of the request; boot_req is never looked at again.
      S_IDLE: begin
        if (bus.boot_req) begin
          state_d = S_WAIT_IDLE;
          phase_d = '0;
        end
      end

      // phase_q counts consecutive idle cycles of the bootloader's flash traffic.
      S_WAIT_IDLE: begin
        if (bus.spi_busy) begin
          phase_d = '0;
        end else if (phase_q == 8'd1) begin
          own_d   = 1'b1;
          phase_d = '0;
          state_d = S_CS_SETUP;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      S_CS_SETUP: begin
        if (phase_q == PHASE_LAST) begin
          cs_d    = 1'b0;
          mosi_d  = SPI_CMD[7];
          sck_d   = 1'b0;
          bit_d   = '0;
          phase_d = '0;
          state_d = S_SHIFT;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      // mosi only moves together with the falling sck, so it is stable at every rise.
      S_SHIFT: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = S_CS_HOLD;
            end else begin
              bit_d  = bit_q + 3'd1;
              mosi_d = SPI_CMD[3'd6 - bit_q];
            end
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      S_CS_HOLD: begin
        if (phase_q == PHASE_LAST) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          guard_d = '0;
          state_d = S_GUARD;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      S_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          boot_d  = 1'b1;
          state_d = S_BOOT;
        end else begin
          guard_d = guard_q + 20'd1;
        end
      end

      S_BOOT: begin
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.spi_own       = own_q;
  assign bus.spi_cs        = cs_q;
  assign bus.spi_sck       = sck_q;
  assign bus.spi_mosi      = mosi_q;
  assign bus.warmboot_s    = IMAGE_SEL;
  assign bus.warmboot_boot = boot_q;
  assign bus.state_dbg     = state_q;

endmodule
